// File: rtl/neuron_weight_sequencer.sv
// Purpose: one neuron's MAC sequencer; streams NUM_WEIGHT activations against a registered-read weight ROM, adds bias, saturates.
// Latency: out_valid rises 3 cycles after the last input handshake (cycle 33 from start with in_valid held high).
// Backpressure: input gaps stall the walk indefinitely; the result is held in OUT until out_ready.
module neuron_weight_sequencer #(
  parameter int NUM_WEIGHT = 30,
  parameter int ADDR_W     = $clog2(NUM_WEIGHT),
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     w_ren,
  output logic [ADDR_W-1:0]        w_radd,
  input  logic signed [DATA_W-1:0] w_rdata,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready
);

  // Wide enough that NUM_WEIGHT full-precision products plus the bias never overflow.
  localparam int ACC_W = 2*DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, BIAS, OUT} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_W-1:0]          idx;
  logic signed [ACC_W-1:0]    acc;
  logic                       pend;
  logic signed [DATA_W-1:0]   x_q;
  logic                       in_hs, out_hs;

  logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_sh, sum, shifted;
  logic signed [DATA_W-1:0]   sat;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign w_ren  = in_hs;
  assign w_radd = idx;

  // Full-precision product of the registered activation and the weight that arrives one cycle later.
  assign x_ext    = (2*DATA_W)'(x_q);
  assign w_ext    = (2*DATA_W)'(w_rdata);
  assign prod     = x_ext * w_ext;
  assign prod_ext = ACC_W'(prod);

  // Bias is aligned to the product's Q format before the floor shift back to DATA_W.
  assign bias_sh  = ACC_W'(bias) <<< FRAC_BITS;
  assign sum      = acc + bias_sh;
  assign shifted  = sum >>> FRAC_BITS;
  assign sat      = (shifted > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                    (shifted < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : shifted[DATA_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control outputs; start only counts in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid && idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = BIAS;
      BIAS:  state_nxt = OUT;
      OUT: begin
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk, accumulate one cycle behind each handshake, and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      x_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      pend <= in_hs;
      if (in_hs) begin
        x_q <= in_data;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
      if (pend) acc <= acc + prod_ext;
      if (state == IDLE && start) begin
        idx  <= '0;
        acc  <= '0;
        pend <= 1'b0;
      end
      if (state == BIAS) begin
        out_data  <= sat;
        out_valid <= 1'b1;
      end
      if (out_hs) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// Purpose: directed checks of the neuron MAC sequencer against hand-computed results.
// Latency: expects out_valid at cycle 33 after start with in_valid held high.
// Backpressure: exercises random input gaps and a held-low out_ready.
module tb_neuron_weight_sequencer;
  localparam int NW = 30;
  localparam int AW = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst, start, busy, done, in_valid, in_ready, w_ren, out_valid, out_ready;
  logic [AW-1:0] w_radd;
  logic signed [DW-1:0] in_data, w_rdata, bias, out_data, wval;

  int checks = 0;
  int errors = 0;

  // Observations recorded by run_eval.
  int ren_cnt, addr_bad, out_cyc, done_cyc, done_cnt, done_bad, stable_bad;
  bit finished, timed_out, rst_hit;
  bit busy0, busy1, ov0, rdy0, ren0;
  logic signed [DW-1:0] result;
  logic s_busy, s_done, s_rdy, s_ren, s_ov;
  logic signed [DW-1:0] s_data;
  logic [AW-1:0] s_radd;

  always #5 clk = ~clk;

  // Registered-read weight ROM: every word holds wval.
  always @(posedge clk) if (w_ren) w_rdata <= wval;

  neuron_weight_sequencer #(.NUM_WEIGHT(NW), .ADDR_W(AW), .DATA_W(DW), .FRAC_BITS(12)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_ren(w_ren), .w_radd(w_radd), .w_rdata(w_rdata), .bias(bias),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  // Drives one evaluation starting in the current cycle (caller is just after a rising edge).
  task automatic run_eval(input logic signed [DW-1:0] w, input logic signed [DW-1:0] x,
                          input logic signed [DW-1:0] b, input bit rnd, input int hold_lo,
                          input int poke_at, input int rst_at);
    int ov_cnt;
    bit seen_ov;
    logic signed [DW-1:0] first_d;
    wval = w; bias = b; in_data = x;
    ren_cnt = 0; addr_bad = 0; out_cyc = -1; done_cyc = -1; done_cnt = 0; done_bad = 0;
    stable_bad = 0; finished = 0; timed_out = 0; rst_hit = 0;
    ov_cnt = 0; seen_ov = 0; first_d = '0;
    for (int cyc = 0; cyc < 1000 && !finished && !rst_hit; cyc++) begin
      start     = (cyc == 0) || (cyc == poke_at);
      in_valid  = rnd ? ($urandom_range(0, 99) < 40) : 1'b1;
      out_ready = (ov_cnt >= hold_lo);
      @(negedge clk);
      if (cyc == 0) begin busy0 = busy; ov0 = out_valid; rdy0 = in_ready; ren0 = w_ren; end
      if (cyc == 1) busy1 = busy;
      if (w_ren) begin
        if (w_radd !== AW'(ren_cnt)) addr_bad++;
        ren_cnt++;
      end
      if (out_valid) begin
        if (!seen_ov) begin seen_ov = 1; out_cyc = cyc; first_d = out_data; end
        else if (out_data !== first_d) stable_bad++;
        ov_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (!(out_valid && out_ready)) done_bad++;
        result = out_data; done_cyc = cyc; finished = 1;
      end
      @(posedge clk); #1;
      if (rst_at > 0 && ren_cnt == rst_at) begin
        rst = 1'b1; #1;
        s_busy = busy; s_done = done; s_rdy = in_ready; s_ren = w_ren;
        s_ov = out_valid; s_data = out_data; s_radd = w_radd;
        rst_hit = 1;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (!finished && !rst_hit) timed_out = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; in_valid = 1; in_data = 16'sd4096; out_ready = 1; bias = 0; wval = 0;
    #12;
    checks++;
    if ({busy, done, in_ready, w_ren, out_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: busy/done/in_ready/w_ren/out_valid=%b expected 00000",
                         {busy, done, in_ready, w_ren, out_valid});
    end
    checks++;
    if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++;
    if (w_radd !== 5'd0) begin errors++; $display("FAIL reset_w_radd: got %0d expected 0", w_radd); end
    in_valid = 0; out_ready = 0;
    @(posedge clk); #1; rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    run_eval(16'sd256, 16'sd4096, 16'sd0, 0, 0, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
    checks++; if (result !== 16'sd7680) begin errors++; $display("FAIL basic_result: got %0d expected 7680", result); end
    checks++; if (out_cyc != 33) begin errors++; $display("FAIL basic_latency: out_valid at %0d expected 33", out_cyc); end
    checks++; if (done_cnt != 1 || done_bad != 0) begin errors++; $display("FAIL basic_done: count %0d bad %0d expected 1/0", done_cnt, done_bad); end
    checks++; if (ren_cnt != NW) begin errors++; $display("FAIL basic_ren_count: got %0d expected %0d", ren_cnt, NW); end
    checks++; if (addr_bad != 0) begin errors++; $display("FAIL basic_addr_order: %0d out-of-order addresses expected 0", addr_bad); end
    checks++; if ({busy0, busy1} !== 2'b01) begin errors++; $display("FAIL basic_busy: cyc0/cyc1=%b expected 01", {busy0, busy1}); end
    checks++; if ({rdy0, ren0} !== 2'b00) begin errors++; $display("FAIL idle_ignores_valid: in_ready/w_ren=%b expected 00", {rdy0, ren0}); end
    idle(2);
  endtask

  task automatic test_negative_bias;
    run_eval(-16'sd256, 16'sd4096, 16'sd4096, 0, 0, -1, 0);
    checks++; if (timed_out || result !== -16'sd3584) begin errors++; $display("FAIL neg_bias_result: got %0d expected -3584", result); end
    idle(2);
  endtask

  task automatic test_saturation;
    run_eval(16'sd4096, 16'sd4096, 16'sd0, 0, 0, -1, 0);
    checks++; if (timed_out || result !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", result); end
    idle(2);
    run_eval(-16'sd4096, 16'sd4096, 16'sd0, 0, 0, -1, 0);
    checks++; if (timed_out || result !== 16'sh8000) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", result); end
    idle(2);
  endtask

  task automatic test_backpressure;
    run_eval(16'sd256, 16'sd4096, 16'sd0, 1, 5, -1, 0);
    checks++; if (timed_out || result !== 16'sd7680) begin errors++; $display("FAIL bp_result: got %0d expected 7680", result); end
    checks++; if (ren_cnt != NW || addr_bad != 0) begin errors++; $display("FAIL bp_reads: count %0d bad %0d expected %0d/0", ren_cnt, addr_bad, NW); end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_hold: out_data changed %0d times expected 0", stable_bad); end
    checks++; if (done_cyc - out_cyc != 5 || done_cnt != 1 || done_bad != 0) begin
      errors++; $display("FAIL bp_done: wait %0d count %0d bad %0d expected 5/1/0", done_cyc - out_cyc, done_cnt, done_bad);
    end
    idle(2);
  endtask

  task automatic test_start_in_fetch;
    run_eval(16'sd256, 16'sd4096, 16'sd0, 0, 0, 5, 0);
    checks++; if (timed_out || result !== 16'sd7680) begin errors++; $display("FAIL restart_result: got %0d expected 7680", result); end
    checks++; if (out_cyc != 33 || ren_cnt != NW || addr_bad != 0) begin
      errors++; $display("FAIL restart_walk: out at %0d reads %0d bad %0d expected 33/%0d/0", out_cyc, ren_cnt, addr_bad, NW);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    run_eval(16'sd256, 16'sd4096, 16'sd0, 0, 0, -1, 10);
    checks++; if (!rst_hit) begin errors++; $display("FAIL midrst_reach: reset point not reached"); end
    checks++; if ({s_busy, s_done, s_rdy, s_ren, s_ov} !== 5'b0 || s_data !== 16'sd0 || s_radd !== 5'd0) begin
      errors++; $display("FAIL midrst_outputs: ctrl=%b data=%0d radd=%0d expected 00000/0/0",
                         {s_busy, s_done, s_rdy, s_ren, s_ov}, s_data, s_radd);
    end
    idle(2); rst = 1'b0; idle(2);
    checks++; if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL midrst_quiet: ov/busy/done=%b expected 000", {out_valid, busy, done}); end
    run_eval(16'sd256, 16'sd4096, 16'sd0, 0, 0, -1, 0);
    checks++; if (timed_out || result !== 16'sd7680) begin errors++; $display("FAIL midrst_rerun: got %0d expected 7680", result); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    // Start raised in the output handshake cycle must be ignored.
    run_eval(16'sd256, 16'sd4096, 16'sd0, 0, 0, 33, 0);
    checks++; if (timed_out || result !== 16'sd7680) begin errors++; $display("FAIL b2b_first: got %0d expected 7680", result); end
    run_eval(-16'sd256, 16'sd4096, 16'sd4096, 0, 0, -1, 0);
    checks++; if ({busy0, ov0} !== 2'b00) begin errors++; $display("FAIL b2b_idle_after_done: busy/out_valid=%b expected 00", {busy0, ov0}); end
    checks++; if (timed_out || result !== -16'sd3584) begin errors++; $display("FAIL b2b_second: got %0d expected -3584", result); end
    checks++; if (out_cyc != 33) begin errors++; $display("FAIL b2b_latency: out_valid at %0d expected 33", out_cyc); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_bias();
    test_saturation();
    test_backpressure();
    test_start_in_fetch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
